// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: resolves rs1/rs2 by forwarding from MEM/WB,
// stalls on load-use hazards, and registers operands into ID/EX via valid/ready.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             upstream handshake with decoded fields
//   in_rs1/rs2/rd, in_wen,
//   in_is_load, in_imm, in_pc     decoded instruction fields
//   rf_rs1/rf_rs2, rf_rd1/rf_rd2  register-file read port (comb address)
//   mem_*                         instruction currently in MEM
//   wb_*                          write being committed this cycle
//   flush                         kill held and incoming instruction
//   out_valid/out_ready           ID/EX handshake
//   out_op_a/op_b/imm/pc/rd/
//   out_wen/out_is_load           registered ID/EX bundle
//   stall_cnt                     saturating load-use stall cycle count
module operand_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   input  logic        in_is_load,
   input  logic [63:0] in_imm,
   input  logic [63:0] in_pc,
   output logic [4:0]  rf_rs1,
   output logic [4:0]  rf_rs2,
   input  logic [63:0] rf_rd1,
   input  logic [63:0] rf_rd2,
   input  logic        mem_valid,
   input  logic        mem_wen,
   input  logic        mem_is_load,
   input  logic [4:0]  mem_rd,
   input  logic [63:0] mem_wd,
   input  logic        wb_wen,
   input  logic [4:0]  wb_rd,
   input  logic [63:0] wb_wd,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_op_a,
   output logic [63:0] out_op_b,
   output logic [63:0] out_imm,
   output logic [63:0] out_pc,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic        out_is_load,
   output logic [31:0] stall_cnt
);

   logic        valid_q, valid_d;
   logic [63:0] op_a_q, op_a_d;
   logic [63:0] op_b_q, op_b_d;
   logic [63:0] imm_q, pc_q;
   logic [4:0]  rd_q;
   logic        wen_q, is_load_q;
   logic [31:0] stall_q, stall_d;

   logic        mem_fwd_ok;
   logic        ex_ld_busy;
   logic        mem_ld_busy;
   logic        haz_rs1, haz_rs2;
   logic        hazard;
   logic        accept;

   assign rf_rs1 = in_rs1;
   assign rf_rs2 = in_rs2;

   // A load's result is not yet available in MEM, so it is never forwarded.
   assign mem_fwd_ok = mem_valid && mem_wen && !mem_is_load;

   // WB bypass is needed because the regfile write lands at the edge,
   // so a same-cycle read still returns the old value.
   always_comb begin
      op_a_d = rf_rd1;
      if (in_rs1 == 5'd0)
         op_a_d = '0;
      else if (mem_fwd_ok && mem_rd == in_rs1)
         op_a_d = mem_wd;
      else if (wb_wen && wb_rd == in_rs1)
         op_a_d = wb_wd;
   end

   always_comb begin
      op_b_d = rf_rd2;
      if (in_rs2 == 5'd0)
         op_b_d = '0;
      else if (mem_fwd_ok && mem_rd == in_rs2)
         op_b_d = mem_wd;
      else if (wb_wen && wb_rd == in_rs2)
         op_b_d = wb_wd;
   end

   // A load in ID/EX or in MEM cannot supply data yet.
   assign ex_ld_busy  = valid_q && is_load_q && wen_q;
   assign mem_ld_busy = mem_valid && mem_is_load && mem_wen;

   assign haz_rs1 = (in_rs1 != 5'd0) &&
                    ((ex_ld_busy && rd_q == in_rs1) ||
                     (mem_ld_busy && mem_rd == in_rs1));
   assign haz_rs2 = (in_rs2 != 5'd0) &&
                    ((ex_ld_busy && rd_q == in_rs2) ||
                     (mem_ld_busy && mem_rd == in_rs2));

   assign hazard   = in_valid && (haz_rs1 || haz_rs2);
   assign in_ready = !flush && !hazard && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      if (flush)
         valid_d = 1'b0;
      else if (accept)
         valid_d = 1'b1;
      else if (out_ready)
         valid_d = 1'b0;
   end

   always_comb begin
      stall_d = stall_q;
      if (hazard && !flush && stall_q != 32'hFFFF_FFFF)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         imm_q     <= '0;
         pc_q      <= '0;
         rd_q      <= '0;
         wen_q     <= 1'b0;
         is_load_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         valid_q <= valid_d;
         stall_q <= stall_d;
         // Held operands were resolved at capture and are not re-forwarded.
         if (accept) begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            imm_q     <= in_imm;
            pc_q      <= in_pc;
            rd_q      <= in_rd;
            wen_q     <= in_wen;
            is_load_q <= in_is_load;
         end
      end
   end

   assign out_valid   = valid_q;
   assign out_op_a    = op_a_q;
   assign out_op_b    = op_b_q;
   assign out_imm     = imm_q;
   assign out_pc      = pc_q;
   assign out_rd      = rd_q;
   assign out_wen     = wen_q;
   assign out_is_load = is_load_q;
   assign stall_cnt   = stall_q;

endmodule

// File: doc/operand_stage.md
# operand_stage

Decode-to-execute operand stage of the 64-bit RISC-V pipeline. It drives the register file's two asynchronous read ports and resolves each source operand by forwarding from the MEM and WB stages. It stalls on load-use hazards and registers the resolved operands into the ID/EX pipeline register behind a valid/ready handshake.

## Interface
- No parameters. Widths are fixed: XLEN = 64, register index = 5 bits.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2, in_rd  in  5  source/destination indices
- in_wen  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_imm, in_pc  in  64  immediate, PC (passed through)
- rf_rs1, rf_rs2  out  5  register-file read addresses (= in_rs1/in_rs2, combinational)
- rf_rd1, rf_rd2  in  64  register-file read data (x0 reads 0)
- mem_valid, mem_wen, mem_is_load  in  1  instruction in MEM stage
- mem_rd  in  5; mem_wd  in  64  MEM result (meaningful only when not a load)
- wb_wen  in  1; wb_rd  in  5; wb_wd  in  64  write being committed to register file this cycle
- flush  in  1  kill held and incoming instruction (branch/jump redirect)
- out_valid  out  1; out_ready  in  1  ID/EX handshake
- out_op_a, out_op_b, out_imm, out_pc  out  64  resolved operands, passthroughs
- out_rd  out  5; out_wen, out_is_load  out  1
- stall_cnt  out  32  saturating count of load-use stall cycles

## Operation
- Operand resolution for rs1 and rs2, evaluated independently, in priority order:
  1. index == 0 → 0.
  2. mem_valid && mem_wen && !mem_is_load && mem_rd == index → mem_wd.
  3. wb_wen && wb_rd == index → wb_wd. Required because the register-file write is synchronous, so a same-cycle read returns the old value.
  4. Otherwise rf_rd1/rf_rd2.
- Load-use hazard on an operand index r ≠ 0 exists when either holds:
  - out_valid && out_is_load && out_wen && out_rd == r
  - mem_valid && mem_is_load && mem_wen && mem_rd == r
- hazard = in_valid && (hazard on rs1 || hazard on rs2).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, at the next edge:
  - resolved operands and all in_* passthroughs load into the out_* registers;
  - out_valid <= 1.
- Out register when there is no accept:
  - out_ready && out_valid → out_valid <= 0; data registers hold.
  - !out_ready → out register holds unchanged. Its operands were captured already resolved and are never re-forwarded.
- flush (highest priority): next edge out_valid <= 0. in_ready is 0 during the flush cycle, so nothing is accepted.
- stall_cnt increments on each cycle with hazard && !flush and saturates at 0xFFFF_FFFF.
- Reset: out_valid = 0, all out_* data = 0, stall_cnt = 0, applied immediately on rst_n low. Reset during a held instruction discards it.

## Timing
- Latency: one cycle from accept to out_valid.
- Full throughput: one instruction per cycle when there is no hazard and out_ready = 1.
- Load-use case: a dependent instruction directly behind a load stalls while the load sits in ID/EX and then in MEM. It is accepted in the cycle the load's data appears on wb_wd, so the typical stall is 2 cycles.
- in_ready depends combinationally on out_ready, flush and the mem_*/wb_* inputs. No combinational path exists from in_valid to in_ready other than through hazard.
- out_* are registered only. rf_rs1/rf_rs2 are purely combinational.
- Upstream holds in_* stable while in_valid && !in_ready. Downstream holds out_ready semantics per standard valid/ready.

## Test plan
- Reset, then regfile x5 = 7 and x6 = 3: accept add x7,x5,x6 with out_ready = 1 → next cycle out_valid = 1, op_a = 7, op_b = 3, rd = 7.
- Forward priority: mem_rd = wb_rd = 5, mem_wd = 11, wb_wd = 22, regfile x5 = 7; read rs1 = 5 → op_a = 11. Drop mem_wen → 22. Then rs1 = 0 with mem_rd = 0 → op_a = 0.
- Load-use: ld x8, then add x9,x8,x8 on the next cycle → in_ready = 0 for 2 cycles and stall_cnt = 2. Accepted when wb_rd = 8, wb_wd = 0x1234; op_a = op_b = 0x1234.
- Backpressure: out_ready = 0 for 3 cycles with in_valid held → out fields stable and in_ready = 0 throughout. Raise out_ready → next instruction accepted the same cycle.
- Flush while out_valid = 1 and in_valid = 1 → next cycle out_valid = 0 and the incoming instruction is not accepted.
- Assert rst_n low mid-stream with out_valid = 1 → out_valid = 0 and stall_cnt = 0 immediately, without waiting for a clock edge.
